// File: rtl/riscv_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// riscv_ctrl_pkg
// Shared encodings for the multi-cycle RV32I control path: opcode constants,
// FSM state codes, instruction classes and the datapath mux select codes
// (pc_src, wb_sel, alu_src_a, alu_op, imm_sel). The immediate generator and
// the datapath muxes decode the same values, so change them only here.
// ---------------------------------------------------------------------------
package riscv_ctrl_pkg;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // FSM state codes
    typedef logic [2:0] state_t;
    localparam state_t ST_RESET  = 3'd0;
    localparam state_t ST_FETCH  = 3'd1;
    localparam state_t ST_DECODE = 3'd2;
    localparam state_t ST_EXEC   = 3'd3;
    localparam state_t ST_MEM    = 3'd4;
    localparam state_t ST_WB     = 3'd5;
    localparam state_t ST_TRAP   = 3'd6;

    // Instruction classes produced by ctrl_decode
    typedef enum logic [3:0] {
        CLS_R       = 4'd0,
        CLS_OP_IMM  = 4'd1,
        CLS_LOAD    = 4'd2,
        CLS_STORE   = 4'd3,
        CLS_BRANCH  = 4'd4,
        CLS_JAL     = 4'd5,
        CLS_JALR    = 4'd6,
        CLS_LUI     = 4'd7,
        CLS_AUIPC   = 4'd8,
        CLS_ILLEGAL = 4'd9
    } op_class_e;

    // Next-PC source
    localparam logic [1:0] PC_SRC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_SRC_IMM   = 2'b01;
    localparam logic [1:0] PC_SRC_ALU   = 2'b10;

    // Register write-back source
    localparam logic [1:0] WB_SEL_ALU   = 2'b00;
    localparam logic [1:0] WB_SEL_MEM   = 2'b01;
    localparam logic [1:0] WB_SEL_PC4   = 2'b10;

    // ALU operand A source
    localparam logic [1:0] SRC_A_RS1    = 2'b00;
    localparam logic [1:0] SRC_A_PC     = 2'b01;
    localparam logic [1:0] SRC_A_ZERO   = 2'b10;

    // ALU operand B source
    localparam logic       SRC_B_RS2    = 1'b0;
    localparam logic       SRC_B_IMM    = 1'b1;

    // ALU operation
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_CMP   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    // Immediate format
    localparam logic [2:0] IMM_I        = 3'b000;
    localparam logic [2:0] IMM_S        = 3'b001;
    localparam logic [2:0] IMM_B        = 3'b010;
    localparam logic [2:0] IMM_J        = 3'b011;
    localparam logic [2:0] IMM_U        = 3'b100;

endpackage

// File: rtl/ctrl_decode.sv
// ---------------------------------------------------------------------------
// ctrl_decode
// Purely combinational major-opcode decoder.
//   opcode   in  7  instr[6:0] or the latched op_q
//   op_class out    instruction class (CLS_ILLEGAL for unknown opcodes)
//   legal    out 1  opcode is one of the nine supported RV32I major opcodes
//   imm_sel  out 3  immediate format the class needs (I for classes without one)
// ---------------------------------------------------------------------------
module ctrl_decode
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_e  op_class,
    output logic       legal,
    output logic [2:0] imm_sel
);

    always_comb begin
        op_class = CLS_ILLEGAL;
        legal    = 1'b0;
        imm_sel  = IMM_I;
        case (opcode)
            OPC_OP: begin
                op_class = CLS_R;
                legal    = 1'b1;
            end
            OPC_OP_IMM: begin
                op_class = CLS_OP_IMM;
                legal    = 1'b1;
            end
            OPC_LOAD: begin
                op_class = CLS_LOAD;
                legal    = 1'b1;
            end
            OPC_STORE: begin
                op_class = CLS_STORE;
                legal    = 1'b1;
                imm_sel  = IMM_S;
            end
            OPC_BRANCH: begin
                op_class = CLS_BRANCH;
                legal    = 1'b1;
                imm_sel  = IMM_B;
            end
            OPC_JAL: begin
                op_class = CLS_JAL;
                legal    = 1'b1;
                imm_sel  = IMM_J;
            end
            OPC_JALR: begin
                op_class = CLS_JALR;
                legal    = 1'b1;
            end
            OPC_LUI: begin
                op_class = CLS_LUI;
                legal    = 1'b1;
                imm_sel  = IMM_U;
            end
            OPC_AUIPC: begin
                op_class = CLS_AUIPC;
                legal    = 1'b1;
                imm_sel  = IMM_U;
            end
            default: begin
                op_class = CLS_ILLEGAL;
                legal    = 1'b0;
                imm_sel  = IMM_I;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Main control FSM of the sequential RV32I core. Steps the shared datapath
// through fetch / decode / execute / memory / writeback, one instruction at a
// time, and parks in TRAP on an illegal opcode until reset.
//
// state  | meaning
// -------+-------------------------------------------------------------
// RESET  | all outputs low, go to FETCH
// FETCH  | read instruction at PC; IR loads on the mem_ready cycle
// DECODE | latch opcode into op_q, legal -> EXEC, illegal -> TRAP
// EXEC   | drive ALU selects for the class; branches retire here
// MEM    | data access at ALU result; stores retire on mem_ready
// WB     | register write and PC update; retires the instruction
// TRAP   | halted=1, everything else low, left only by reset
//
// Ports:
//   clk, rst_n      clock and synchronous active-low reset
//   instr           IR contents (only [6:0] decoded)
//   branch_taken    ALU compare result, used in EXEC
//   mem_ready       completes the pending memory request
//   mem_req/mem_we  memory request and direction
//   addr_sel        0 = PC, 1 = ALU result
//   ir_we/pc_we/reg_we  architectural write enables
//   pc_src, wb_sel, alu_src_a, alu_src_b, alu_op, imm_sel  datapath selects
//   instr_retired   pulse on the last cycle of each instruction
//   halted          high in TRAP
// ---------------------------------------------------------------------------
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        branch_taken,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic [1:0]  alu_src_a,
    output logic        alu_src_b,
    output logic [1:0]  alu_op,
    output logic [2:0]  imm_sel,
    output logic        instr_retired,
    output logic        halted
);

    state_t     state_q;
    state_t     state_d;
    logic [6:0] op_q;

    op_class_e  instr_class;
    logic       instr_legal;
    logic [2:0] instr_imm_sel;

    op_class_e  op_class;
    logic       op_legal;
    logic [2:0] op_imm_sel;

    // Legality check on the live IR during DECODE
    ctrl_decode u_dec_instr (
        .opcode   (instr[6:0]),
        .op_class (instr_class),
        .legal    (instr_legal),
        .imm_sel  (instr_imm_sel)
    );

    // Class of the latched opcode; drives all EXEC/MEM/WB outputs
    ctrl_decode u_dec_op (
        .opcode   (op_q),
        .op_class (op_class),
        .legal    (op_legal),
        .imm_sel  (op_imm_sel)
    );

    logic unused_bits;
    assign unused_bits = ^{instr[31:7], instr_class, instr_imm_sel, op_legal};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RESET;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                op_q <= instr[6:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:  state_d = ST_FETCH;
            ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: state_d = instr_legal ? ST_EXEC : ST_TRAP;
            ST_EXEC: begin
                case (op_class)
                    CLS_BRANCH:          state_d = ST_FETCH;
                    CLS_LOAD, CLS_STORE: state_d = ST_MEM;
                    default:             state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (mem_ready) begin
                    state_d = (op_class == CLS_STORE) ? ST_FETCH : ST_WB;
                end
            end
            ST_WB:     state_d = ST_FETCH;
            ST_TRAP:   state_d = ST_TRAP;
            default:   state_d = ST_RESET;
        endcase
    end

    // ALU/immediate selects for the latched class. They are driven in EXEC and
    // held through MEM and WB so the ALU result (address or write data) is
    // stable for the whole instruction.
    logic [1:0] ex_alu_op;
    logic [1:0] ex_src_a;
    logic       ex_src_b;

    always_comb begin
        ex_alu_op = ALU_OP_ADD;
        ex_src_a  = SRC_A_RS1;
        ex_src_b  = SRC_B_RS2;
        case (op_class)
            CLS_R:       ex_alu_op = ALU_OP_FUNCT;
            CLS_OP_IMM: begin
                ex_alu_op = ALU_OP_FUNCT;
                ex_src_b  = SRC_B_IMM;
            end
            CLS_LOAD,
            CLS_STORE,
            CLS_JALR:    ex_src_b  = SRC_B_IMM;
            CLS_BRANCH:  ex_alu_op = ALU_OP_CMP;
            CLS_LUI: begin
                ex_src_a  = SRC_A_ZERO;
                ex_src_b  = SRC_B_IMM;
            end
            CLS_AUIPC: begin
                ex_src_a  = SRC_A_PC;
                ex_src_b  = SRC_B_IMM;
            end
            default: begin
                ex_alu_op = ALU_OP_ADD;
                ex_src_a  = SRC_A_RS1;
                ex_src_b  = SRC_B_RS2;
            end
        endcase
    end

    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        addr_sel      = 1'b0;
        ir_we         = 1'b0;
        pc_we         = 1'b0;
        pc_src        = PC_SRC_PLUS4;
        reg_we        = 1'b0;
        wb_sel        = WB_SEL_ALU;
        alu_src_a     = SRC_A_RS1;
        alu_src_b     = SRC_B_RS2;
        alu_op        = ALU_OP_ADD;
        imm_sel       = IMM_I;
        instr_retired = 1'b0;
        halted        = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
            end
            ST_EXEC: begin
                alu_op    = ex_alu_op;
                alu_src_a = ex_src_a;
                alu_src_b = ex_src_b;
                imm_sel   = op_imm_sel;
                if (op_class == CLS_BRANCH) begin
                    pc_we         = 1'b1;
                    pc_src        = branch_taken ? PC_SRC_IMM : PC_SRC_PLUS4;
                    instr_retired = 1'b1;
                end
            end
            ST_MEM: begin
                alu_op    = ex_alu_op;
                alu_src_a = ex_src_a;
                alu_src_b = ex_src_b;
                imm_sel   = op_imm_sel;
                mem_req   = 1'b1;
                addr_sel  = 1'b1;
                mem_we    = (op_class == CLS_STORE);
                // A store has nothing to write back, so it retires here.
                if (mem_ready && (op_class == CLS_STORE)) begin
                    pc_we         = 1'b1;
                    instr_retired = 1'b1;
                end
            end
            ST_WB: begin
                alu_op        = ex_alu_op;
                alu_src_a     = ex_src_a;
                alu_src_b     = ex_src_b;
                imm_sel       = op_imm_sel;
                reg_we        = 1'b1;
                pc_we         = 1'b1;
                instr_retired = 1'b1;
                case (op_class)
                    CLS_LOAD:           wb_sel = WB_SEL_MEM;
                    CLS_JAL, CLS_JALR:  wb_sel = WB_SEL_PC4;
                    default:            wb_sel = WB_SEL_ALU;
                endcase
                case (op_class)
                    CLS_JAL:  pc_src = PC_SRC_IMM;
                    CLS_JALR: pc_src = PC_SRC_ALU;
                    default:  pc_src = PC_SRC_PLUS4;
                endcase
            end
            ST_TRAP:  halted = 1'b1;
            default: begin
                halted = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;
    import riscv_ctrl_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        branch_taken;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        addr_sel;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  pc_src;
    logic        reg_we;
    logic [1:0]  wb_sel;
    logic [1:0]  alu_src_a;
    logic        alu_src_b;
    logic [1:0]  alu_op;
    logic [2:0]  imm_sel;
    logic        instr_retired;
    logic        halted;

    int checks = 0;
    int errors = 0;

    multicycle_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr         (instr),
        .branch_taken  (branch_taken),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .addr_sel      (addr_sel),
        .ir_we         (ir_we),
        .pc_we         (pc_we),
        .pc_src        (pc_src),
        .reg_we        (reg_we),
        .wb_sel        (wb_sel),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .imm_sel       (imm_sel),
        .instr_retired (instr_retired),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All outputs packed, MSB first in port order (20 bits)
    logic [19:0] outs;
    assign outs = {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, reg_we,
                   wb_sel, alu_src_a, alu_src_b, alu_op, imm_sel,
                   instr_retired, halted};

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input state_t exp);
        chk(tag, 32'(dut.state_q), 32'(exp));
    endtask

    initial begin
        rst_n        = 1'b0;
        instr        = 32'h0000_0000;
        branch_taken = 1'b0;
        mem_ready    = 1'b0;
        cycle();
        cycle();
        chk_state("rst_state", ST_RESET);
        chk("rst_outs", 32'(outs), 32'h0);

        // addi x1,x0,5 with zero-wait memory
        instr     = 32'h0050_0093;
        mem_ready = 1'b1;
        rst_n     = 1'b1;
        cycle();
        chk_state("addi_fetch", ST_FETCH);
        chk("addi_f_req", 32'(mem_req), 1);
        chk("addi_f_addr", 32'(addr_sel), 0);
        chk("addi_f_we", 32'(mem_we), 0);
        chk("addi_f_irwe", 32'(ir_we), 1);
        cycle();
        chk_state("addi_decode", ST_DECODE);
        chk("addi_d_outs", 32'(outs), 32'h0);
        cycle();
        chk_state("addi_exec", ST_EXEC);
        chk("addi_e_aluop", 32'(alu_op), 2);
        chk("addi_e_srcb", 32'(alu_src_b), 1);
        chk("addi_e_imm", 32'(imm_sel), 0);
        chk("addi_e_regwe", 32'(reg_we), 0);
        cycle();
        chk_state("addi_wb", ST_WB);
        chk("addi_wb_regwe", 32'(reg_we), 1);
        chk("addi_wb_wbsel", 32'(wb_sel), 0);
        chk("addi_wb_pcsrc", 32'(pc_src), 0);
        chk("addi_wb_pcwe", 32'(pc_we), 1);
        chk("addi_wb_ret", 32'(instr_retired), 1);
        chk("addi_wb_aluop", 32'(alu_op), 2);
        cycle();
        chk_state("addi_next_fetch", ST_FETCH);
        chk("addi_next_ret", 32'(instr_retired), 0);

        // lw x2,0(x1) with two wait cycles in MEM: cycle 1 is this FETCH
        instr = 32'h0000_A103;
        cycle();
        chk_state("lw_decode", ST_DECODE);
        cycle();
        chk_state("lw_exec", ST_EXEC);
        chk("lw_e_srcb", 32'(alu_src_b), 1);
        chk("lw_e_imm", 32'(imm_sel), 0);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 0) cycle();
            chk_state("lw_mem", ST_MEM);
            chk("lw_m_req", 32'(mem_req), 1);
            chk("lw_m_addr", 32'(addr_sel), 1);
            chk("lw_m_we", 32'(mem_we), 0);
            chk("lw_m_srcb", 32'(alu_src_b), 1);
            chk("lw_m_regwe", 32'(reg_we), 0);
            chk("lw_m_pcwe", 32'(pc_we), 0);
            if (i == 2) begin
                mem_ready = 1'b1;
                #1;
                chk("lw_m_ready_pcwe", 32'(pc_we), 0);
            end
            cycle();
        end
        chk_state("lw_wb", ST_WB);
        chk("lw_wb_wbsel", 32'(wb_sel), 1);
        chk("lw_wb_regwe", 32'(reg_we), 1);
        chk("lw_wb_ret", 32'(instr_retired), 1);
        cycle();
        chk_state("lw_fetch_after_7", ST_FETCH);

        // beq taken
        instr        = 32'h0000_0463;
        branch_taken = 1'b1;
        cycle();
        cycle();
        chk_state("beq_t_exec", ST_EXEC);
        chk("beq_t_pcwe", 32'(pc_we), 1);
        chk("beq_t_pcsrc", 32'(pc_src), 1);
        chk("beq_t_ret", 32'(instr_retired), 1);
        chk("beq_t_imm", 32'(imm_sel), 2);
        chk("beq_t_aluop", 32'(alu_op), 1);
        chk("beq_t_regwe", 32'(reg_we), 0);
        cycle();
        chk_state("beq_t_no_wb", ST_FETCH);

        // beq not taken
        branch_taken = 1'b0;
        cycle();
        cycle();
        chk_state("beq_n_exec", ST_EXEC);
        chk("beq_n_pcsrc", 32'(pc_src), 0);
        chk("beq_n_pcwe", 32'(pc_we), 1);
        cycle();
        chk_state("beq_n_fetch", ST_FETCH);

        // jalr x1,0(x1)
        instr = 32'h0000_80E7;
        cycle();
        cycle();
        chk("jalr_e_srcb", 32'(alu_src_b), 1);
        chk("jalr_e_imm", 32'(imm_sel), 0);
        cycle();
        chk_state("jalr_wb", ST_WB);
        chk("jalr_wb_wbsel", 32'(wb_sel), 2);
        chk("jalr_wb_pcsrc", 32'(pc_src), 2);
        chk("jalr_wb_regwe", 32'(reg_we), 1);
        cycle();

        // lui x1,0x12
        instr = 32'h0001_20B7;
        cycle();
        cycle();
        chk("lui_e_srca", 32'(alu_src_a), 2);
        chk("lui_e_imm", 32'(imm_sel), 4);
        cycle();
        chk("lui_wb_wbsel", 32'(wb_sel), 0);
        chk("lui_wb_srca", 32'(alu_src_a), 2);
        cycle();

        // sw x2,0(x1)
        instr = 32'h0020_A023;
        cycle();
        cycle();
        chk("sw_e_imm", 32'(imm_sel), 1);
        chk("sw_e_regwe", 32'(reg_we), 0);
        cycle();
        chk_state("sw_mem", ST_MEM);
        chk("sw_m_we", 32'(mem_we), 1);
        chk("sw_m_req", 32'(mem_req), 1);
        chk("sw_m_pcwe", 32'(pc_we), 1);
        chk("sw_m_pcsrc", 32'(pc_src), 0);
        chk("sw_m_ret", 32'(instr_retired), 1);
        chk("sw_m_regwe", 32'(reg_we), 0);
        cycle();
        chk_state("sw_fetch", ST_FETCH);
        chk("sw_f_regwe", 32'(reg_we), 0);

        // illegal opcode
        instr = 32'hFFFF_FFFF;
        cycle();
        chk_state("ill_decode", ST_DECODE);
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk_state("ill_trap", ST_TRAP);
            chk("ill_outs", 32'(outs), 32'h1);
        end
        rst_n = 1'b0;
        cycle();
        chk_state("ill_rst", ST_RESET);
        chk("ill_rst_halted", 32'(halted), 0);
        rst_n = 1'b1;
        cycle();
        chk_state("ill_fetch", ST_FETCH);
        chk("ill_f_req", 32'(mem_req), 1);

        // reset during MEM of a load, mem_ready pulsing in the same cycle
        instr = 32'h0000_A103;
        cycle();
        cycle();
        mem_ready = 1'b0;
        cycle();
        chk_state("rmem_mem", ST_MEM);
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("rmem_regwe0", 32'(reg_we), 0);
        chk("rmem_pcwe0", 32'(pc_we), 0);
        cycle();
        chk_state("rmem_reset", ST_RESET);
        chk("rmem_regwe1", 32'(reg_we), 0);
        chk("rmem_pcwe1", 32'(pc_we), 0);
        rst_n     = 1'b1;
        mem_ready = 1'b0;
        cycle();
        chk_state("rmem_fetch", ST_FETCH);
        chk("rmem_f_we", 32'(mem_we), 0);
        chk("rmem_f_req", 32'(mem_req), 1);
        chk("rmem_f_regwe", 32'(reg_we), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
